// File: rtl/multiplication_unit.sv
// ============================================================================
// multiplication_unit : sequential radix-2 shift-add multiplier (RV32M MUL*)
// Rev 1.0
// ============================================================================
`default_nettype none

package multiplication_unit_pkg;
  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_uop_t;
endpackage

module multiplication_unit
  import multiplication_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clk_en_i,
  input  logic [DATA_WIDTH-1:0] multiplicand_i,
  input  logic [DATA_WIDTH-1:0] multiplier_i,
  input  logic                  data_valid_i,
  input  mul_uop_t              operation_i,
  output logic [DATA_WIDTH-1:0] product_o,
  output logic                  data_valid_o,
  output logic                  idle_o
);

  localparam int unsigned           c_cnt_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_cnt_w-1:0]    c_last  = c_cnt_w'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MULTIPLY = 2'd1,
    S_FINISH   = 2'd2
  } state_t;

  state_t                    r_state;
  logic [DATA_WIDTH-1:0]     r_mcand;
  logic [DATA_WIDTH-1:0]     r_mplier;
  logic [2*DATA_WIDTH-1:0]   r_acc;
  logic [c_cnt_w-1:0]        r_count;
  mul_uop_t                  r_op;
  logic                      r_negate;
  logic [DATA_WIDTH-1:0]     r_product;
  logic                      r_valid;
  logic                      r_idle;

  logic                      w_rs1_signed;
  logic                      w_rs2_signed;
  logic                      w_rs1_neg;
  logic                      w_rs2_neg;
  logic [DATA_WIDTH-1:0]     w_rs1_mag;
  logic [DATA_WIDTH-1:0]     w_rs2_mag;
  logic [DATA_WIDTH:0]       w_sum;
  logic [2*DATA_WIDTH-1:0]   w_full;

  assign w_rs1_signed = (operation_i == MULH) || (operation_i == MULHSU);
  assign w_rs2_signed = (operation_i == MULH);
  assign w_rs1_neg    = multiplicand_i[DATA_WIDTH-1] & w_rs1_signed;
  assign w_rs2_neg    = multiplier_i[DATA_WIDTH-1] & w_rs2_signed;
  // The most negative value negates to itself, which read unsigned is exactly its magnitude.
  assign w_rs1_mag    = w_rs1_neg ? (~multiplicand_i + DATA_WIDTH'(1)) : multiplicand_i;
  assign w_rs2_mag    = w_rs2_neg ? (~multiplier_i + DATA_WIDTH'(1)) : multiplier_i;

  // Upper-half add keeps its carry so the right shift loses nothing.
  assign w_sum  = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_full = r_negate ? (~r_acc + (2*DATA_WIDTH)'(1)) : r_acc;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_op      <= MUL;
      r_negate  <= 1'b0;
      r_product <= '0;
      r_valid   <= 1'b0;
      r_idle    <= 1'b1;
    end else if (clk_en_i) begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (data_valid_i) begin
            r_mcand  <= w_rs1_mag;
            r_mplier <= w_rs2_mag;
            r_op     <= operation_i;
            r_negate <= w_rs1_neg ^ w_rs2_neg;
            r_acc    <= '0;
            r_count  <= '0;
            r_idle   <= 1'b0;
            r_state  <= S_MULTIPLY;
          end
        end
        S_MULTIPLY: begin
          r_acc    <= {w_sum, r_acc[DATA_WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + c_cnt_w'(1);
          if (r_count == c_last) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_product <= (r_op == MUL) ? w_full[DATA_WIDTH-1:0]
                                     : w_full[2*DATA_WIDTH-1:DATA_WIDTH];
          r_valid   <= 1'b1;
          r_idle    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_idle  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign product_o    = r_product;
  assign data_valid_o = r_valid;
  assign idle_o       = r_idle;

`ifdef ASSERTIONS
  a_valid_while_busy : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                        !(clk_en_i && data_valid_i && !r_idle))
    else $error("data_valid_i asserted while unit busy");
`endif

endmodule

`default_nettype wire

// File: tb/tb_multiplication_unit.sv
// ============================================================================
// tb_multiplication_unit : scoreboard bench for multiplication_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multiplication_unit;
  import multiplication_unit_pkg::*;

  logic        clk_i;
  logic        rst_n_i;
  logic        clk_en_i;
  logic [31:0] multiplicand_i;
  logic [31:0] multiplier_i;
  logic        data_valid_i;
  mul_uop_t    operation_i;
  logic [31:0] product_o;
  logic        data_valid_o;
  logic        idle_o;

  typedef struct {
    logic [31:0] prod;
    int unsigned acc;
    int unsigned lat;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  logic        prev_valid = 1'b0;

  multiplication_unit #(.DATA_WIDTH(32)) u_dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .clk_en_i       (clk_en_i),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .data_valid_i   (data_valid_i),
    .operation_i    (operation_i),
    .product_o      (product_o),
    .data_valid_o   (data_valid_o),
    .idle_o         (idle_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input mul_uop_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MULH:    p = sa * sb;
      MULHSU:  p = sa * longint'({32'b0, b});
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  // Result monitor: pops the scoreboard on every valid pulse.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      prev_valid <= 1'b0;
    end else begin
      if (prev_valid) check("valid_single_pulse", {31'b0, data_valid_o}, 32'd0);
      if (data_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(e.tag, product_o, e.prod);
          check({e.tag, "_latency"}, cyc - e.acc, e.lat);
          check({e.tag, "_idle"}, {31'b0, idle_o}, 32'd1);
        end
      end
      prev_valid <= data_valid_o;
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!idle_o && n < 200);
    if (!idle_o) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_op(input mul_uop_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int unsigned lat,
                          input string tag, input bit track);
    exp_t e;
    operation_i    = op;
    multiplicand_i = a;
    multiplier_i   = b;
    data_valid_i   = 1'b1;
    @(posedge clk_i);
    #1;
    data_valid_i = 1'b0;
    if (track) begin
      e.prod = exp;
      e.acc  = cyc;
      e.lat  = lat;
      e.tag  = tag;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    int n;
    mul_uop_t    rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] corner [4];
    corner[0] = 32'h8000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h0000_0000;
    corner[3] = 32'h7FFF_FFFF;

    rst_n_i        = 1'b0;
    clk_en_i       = 1'b1;
    data_valid_i   = 1'b0;
    operation_i    = MUL;
    multiplicand_i = '0;
    multiplier_i   = '0;
    repeat (3) @(negedge clk_i);
    check("reset_product", product_o, 32'd0);
    check("reset_valid", {31'b0, data_valid_o}, 32'd0);
    check("reset_idle", {31'b0, idle_o}, 32'd1);
    rst_n_i = 1'b1;

    // Basic latency and idle window
    wait_idle();
    start_op(MUL, 32'd7, 32'd6, 32'h0000_002A, 33, "mul_7x6", 1'b1);
    check("idle_low_after_accept", {31'b0, idle_o}, 32'd0);
    repeat (33) @(negedge clk_i);
    check("idle_low_before_finish", {31'b0, idle_o}, 32'd0);

    wait_idle(); start_op(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul_m1",     1'b1);
    wait_idle(); start_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh_m1",    1'b1);
    wait_idle(); start_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max",  1'b1);
    wait_idle(); start_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1",  1'b1);
    wait_idle(); start_op(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min2",  1'b1);
    wait_idle(); start_op(MULH,   32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 33, "mulh_minx1", 1'b1);
    wait_idle(); start_op(MUL,    32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 33, "mul_min_x2", 1'b1);

    // Back-to-back accepts in the valid cycle
    wait_idle(); start_op(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 33, "b2b_first",  1'b1);
    wait_idle(); start_op(MUL,   32'd1000,      32'd1000,      32'd1000000,   33, "b2b_second", 1'b1);

    // Valid pulse while busy must be ignored
    wait_idle();
    start_op(MULH, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 33, "mulh_inject", 1'b1);
    repeat (10) @(negedge clk_i);
    operation_i    = MUL;
    multiplicand_i = 32'd3;
    multiplier_i   = 32'd3;
    data_valid_i   = 1'b1;
    @(negedge clk_i);
    data_valid_i = 1'b0;

    // Random mix with corner operands, checked against the reference model
    for (int i = 0; i < 16; i++) begin
      rop = mul_uop_t'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      wait_idle();
      start_op(rop, ra, rb, model(rop, ra, rb), 33, $sformatf("rand%0d", i), 1'b1);
    end

    // Clock-enable stall mid-multiply
    wait_idle(); start_op(MUL, 32'd3, 32'd5, 32'd15, 33, "mul_3x5", 1'b1);
    wait_idle(); start_op(MUL, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 38, "mul_stall", 1'b1);
    repeat (10) @(negedge clk_i);
    clk_en_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("stall_idle_hold", {31'b0, idle_o}, 32'd0);
    check("stall_product_hold", product_o, 32'd15);
    clk_en_i = 1'b1;

    // Reset mid-operation aborts with no later pulse
    wait_idle();
    start_op(MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'd0, 33, "aborted", 1'b0);
    repeat (10) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    check("abort_idle", {31'b0, idle_o}, 32'd1);
    check("abort_valid", {31'b0, data_valid_o}, 32'd0);
    check("abort_product", product_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (45) @(negedge clk_i);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multiplication_unit.md
Name: multiplication_unit

Overview:
Sequential integer multiplier for the RV32M MUL/MULH/MULHSU/MULHU operations. It is the complementary arithmetic unit to the division unit, with the same valid/idle handshake, and sits alongside it in the integer execution unit. Operands are converted to magnitudes and multiplied with an iterative radix-2 shift-add datapath. The 2*DATA_WIDTH-bit result is then sign-corrected, and the high or low half is selected.

Parameters:
DATA_WIDTH, 32, operand and result width; iteration count equals DATA_WIDTH.

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
clk_en_i  input  1  clock enable; when low, all state holds
multiplicand_i  input  DATA_WIDTH  rs1 operand
multiplier_i  input  DATA_WIDTH  rs2 operand
data_valid_i  input  1  operands and operation valid; sampled only while idle_o=1
operation_i  input  mul_uop_t  MUL, MULH, MULHSU or MULHU
product_o  output  DATA_WIDTH  selected result half
data_valid_o  output  1  product_o valid; single-cycle pulse
idle_o  output  1  unit can accept a new operation

Behaviour:
- Reset (asynchronous, rst_n_i=0): state=IDLE, product_o=0, data_valid_o=0, idle_o=1, iteration counter=0, accumulator=0. Reset mid-operation aborts the operation; no data_valid_o pulse follows.
- All sequential updates, including the FSM, counter, accumulator and outputs, occur only on rising edges where clk_en_i=1. A cycle with clk_en_i=0 stretches latency by one cycle and leaves every output unchanged.
- Signedness by operation:
  - MULH: rs1 and rs2 signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU and MUL: both unsigned. MUL low half is sign-agnostic.
- A signed negative operand is replaced by its two's-complement magnitude. 0x80000000 maps to unsigned 2^31; no overflow.
- negate_flag = (sign_rs1 & rs1_signed) ^ (sign_rs2 & rs2_signed). It is registered at accept.
- FSM states: IDLE -> MULTIPLY -> FINISH -> IDLE.
  - IDLE: on an edge with data_valid_i=1, register the operand magnitudes, operation and negate_flag. Clear the 2*DATA_WIDTH accumulator and counter, then go to MULTIPLY. idle_o goes to 0 on that same edge.
  - MULTIPLY: each edge examines the multiplier LSB. If the LSB is 1, add the multiplicand into the accumulator upper half with a carry bit. Then shift {carry, accumulator} right by 1 and shift the multiplier right by 1. Counter increments. After iteration DATA_WIDTH (counter==DATA_WIDTH-1), go to FINISH.
  - FINISH: on one edge:
    - full = negate_flag ? (~acc + 1) : acc, computed in 2*DATA_WIDTH-bit two's complement.
    - product_o <= (operation==MUL) ? full[DATA_WIDTH-1:0] : full[2*DATA_WIDTH-1:DATA_WIDTH].
    - data_valid_o <= 1, idle_o <= 1, go to IDLE.
- Latency: accepting edge E0; iterations on E1..E32; result registered on E33. data_valid_o is high in the cycle after E33 for exactly one enabled cycle and cleared on the next enabled edge.
- Throughput: one operation per 34 enabled cycles minimum. A new data_valid_i is accepted in the same cycle data_valid_o is high, because idle_o=1 there. A back-to-back accept clears data_valid_o on that edge and starts the next operation.
- data_valid_i while idle_o=0 is ignored; under ASSERTIONS it is flagged as an error. The in-flight result is unaffected.
- product_o holds its last result until the next FINISH; only data_valid_o qualifies it.
- There is no zero-operand early-out; latency is fixed.

Test Plan:
1. MUL, 7 x 6 accepted at edge E0 -> product_o=0x0000002A with data_valid_o=1 after E33; idle_o=0 from E0 to E33.
2. MUL, then MULH, with 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001, then 0x00000000. MULHU with the same operands -> 0xFFFFFFFE.
3. MULHSU, 0xFFFFFFFF (-1) x 0xFFFFFFFF (2^32-1) -> product_o=0xFFFFFFFF. The full product is 0xFFFFFFFF00000001.
4. MULH, 0x80000000 x 0x80000000 -> 0x40000000. MULH 0x80000000 x 0x00000001 -> 0xFFFFFFFF. MUL 0x80000000 x 0x00000002 -> 0x00000000.
5. Back-to-back: assert a second valid in the data_valid_o cycle -> second result 34 cycles later. A valid pulse injected mid-operation is ignored, and the first result is correct.
6. clk_en_i low for 5 cycles mid-MULTIPLY -> result arrives 5 cycles late and is unchanged. rst_n_i pulsed low mid-operation -> immediately idle_o=1, data_valid_o=0, product_o=0, and no later valid pulse.
